// File: rtl/serdes_write_arbiter.sv
// serdes_write_arbiter
//   Round-robin arbiter that shares one serdes write port among NUM_SRC
//   producers. A granted producer keeps the port for its whole burst; the
//   arbiter then issues a one-cycle serdes flush and waits for the serdes to
//   drain before re-arbitrating, so packed serdes words never mix sources.
//
// Ports
//   clk, reset       clock, synchronous active-low reset
//   src_req          per-source beat valid
//   src_flush        per-source end-of-burst marker
//   src_count        per-source valid operand count (slice i = source i)
//   src_data         per-source beat data (slice i = source i)
//   src_ready        beat taken from source i when src_req[i] is also high
//   src_grant        registered one-hot grant
//   s_write_req      beat valid to the serdes
//   s_write_ready    serdes can take a beat / serdes has drained
//   s_write_flush    one-cycle serdes flush pulse
//   count            valid operand count of the current beat
//   s_write_data     current beat data
//   err_count        sticky: an accepted beat carried count 0 or > IN_COUNT
module serdes_write_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int IN_COUNT  = 10,
  parameter int OP_WIDTH  = 16,
  parameter int IN_WIDTH  = IN_COUNT * OP_WIDTH,
  parameter int COUNT_W   = $clog2(IN_COUNT) + 1,
  parameter int MAX_BURST = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic [NUM_SRC-1:0]          src_flush,
  input  logic [NUM_SRC*COUNT_W-1:0]  src_count,
  input  logic [NUM_SRC*IN_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [NUM_SRC-1:0]          src_grant,
  output logic                        s_write_req,
  input  logic                        s_write_ready,
  output logic                        s_write_flush,
  output logic [COUNT_W-1:0]          count,
  output logic [IN_WIDTH-1:0]         s_write_data,
  output logic                        err_count
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  // Unpacked views of the flat per-source buses.
  logic [COUNT_W-1:0]  cnt_arr [NUM_SRC];
  logic [IN_WIDTH-1:0] dat_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
    assign cnt_arr[i] = src_count[i*COUNT_W +: COUNT_W];
    assign dat_arr[i] = src_data[i*IN_WIDTH +: IN_WIDTH];
  end

  logic                sel_req, sel_flush, accept, count_bad, burst_full;
  logic [COUNT_W-1:0]  sel_count;
  logic [IN_WIDTH-1:0] sel_data;
  logic [BEAT_W-1:0]   beat_inc;

  assign sel_req    = src_req[gidx_q];
  assign sel_flush  = src_flush[gidx_q];
  assign sel_count  = cnt_arr[gidx_q];
  assign sel_data   = dat_arr[gidx_q];
  assign accept     = (state_q == STREAM) && sel_req && s_write_ready;
  assign count_bad  = (sel_count == '0) || (sel_count > COUNT_W'(IN_COUNT));
  assign beat_inc   = beat_cnt_q + BEAT_W'(1);
  assign burst_full = (beat_inc == BEAT_W'(MAX_BURST));

  // Round-robin search: first requester after last_q, wrapping.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_SRC);
      if (!pick_found && src_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q | (accept & count_bad);
    src_ready     = '0;
    s_write_req   = 1'b0;
    s_write_flush = 1'b0;
    count         = '0;
    s_write_data  = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NUM_SRC'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = STREAM;
        end
      end
      STREAM: begin
        src_ready    = grant_q & {NUM_SRC{s_write_ready}};
        s_write_req  = accept;
        count        = sel_count;
        s_write_data = sel_data;
        if (accept) begin
          beat_cnt_d = beat_inc;
        end
        // A flush marker riding on a stalled beat waits until that beat is
        // taken; a bare flush marker (no beat) closes the burst at once.
        if ((sel_flush && (accept || !sel_req)) || (accept && burst_full)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        s_write_flush = 1'b1;
        beat_cnt_d    = '0;
        state_d       = DRAIN;
      end
      DRAIN: begin
        if (s_write_ready) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IDX_W'(NUM_SRC - 1);
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign src_grant = grant_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_serdes_write_arbiter.sv
module tb_serdes_write_arbiter;

  localparam int NUM_SRC  = 4;
  localparam int IN_COUNT = 10;
  localparam int OP_WIDTH = 16;
  localparam int IN_WIDTH = IN_COUNT * OP_WIDTH;
  localparam int COUNT_W  = $clog2(IN_COUNT) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        reset;
  logic [NUM_SRC-1:0]          src_req, src_flush;
  logic [NUM_SRC*COUNT_W-1:0]  src_count;
  logic [NUM_SRC*IN_WIDTH-1:0] src_data;
  logic                        s_write_ready;

  logic [NUM_SRC-1:0]  a_ready, a_grant, b_ready, b_grant;
  logic                a_req, a_flush, a_err, b_req, b_flush, b_err;
  logic [COUNT_W-1:0]  a_count, b_count;
  logic [IN_WIDTH-1:0] a_data, b_data;

  serdes_write_arbiter dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_flush(src_flush),
    .src_count(src_count), .src_data(src_data), .src_ready(a_ready),
    .src_grant(a_grant), .s_write_req(a_req), .s_write_ready(s_write_ready),
    .s_write_flush(a_flush), .count(a_count), .s_write_data(a_data),
    .err_count(a_err));

  serdes_write_arbiter #(.MAX_BURST(4)) dut_mb4 (
    .clk(clk), .reset(reset), .src_req(src_req), .src_flush(src_flush),
    .src_count(src_count), .src_data(src_data), .src_ready(b_ready),
    .src_grant(b_grant), .s_write_req(b_req), .s_write_ready(s_write_ready),
    .s_write_flush(b_flush), .count(b_count), .s_write_data(b_data),
    .err_count(b_err));

  // use4 selects which instance the driver and monitor follow.
  logic use4;
  logic [NUM_SRC-1:0]  mon_ready, mon_grant;
  logic                mon_req, mon_flush, mon_err;
  logic [COUNT_W-1:0]  mon_count;
  logic [IN_WIDTH-1:0] mon_data;
  assign mon_ready = use4 ? b_ready : a_ready;
  assign mon_grant = use4 ? b_grant : a_grant;
  assign mon_req   = use4 ? b_req   : a_req;
  assign mon_flush = use4 ? b_flush : a_flush;
  assign mon_err   = use4 ? b_err   : a_err;
  assign mon_count = use4 ? b_count : a_count;
  assign mon_data  = use4 ? b_data  : a_data;

  typedef struct {
    logic                flush_only;
    logic                last;
    logic [COUNT_W-1:0]  cnt;
    logic [IN_WIDTH-1:0] data;
  } beat_t;

  typedef struct {
    logic                is_flush;
    logic [NUM_SRC-1:0]  grant;
    logic [COUNT_W-1:0]  cnt;
    logic [IN_WIDTH-1:0] data;
    logic                err;
    int                  gap;   // cycles since previous event, 0 = any
  } exp_t;

  beat_t srcq [NUM_SRC][$];
  exp_t  expq [$];
  logic  exp_err;
  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc     = 0;
  int    last_ev = 0;

  task automatic chk(input string name, input logic [IN_WIDTH-1:0] act,
                     input logic [IN_WIDTH-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [IN_WIDTH-1:0] mkdata(input int s, input int k);
    logic [IN_WIDTH-1:0] d;
    d = '0;
    for (int op = 0; op < IN_COUNT; op++)
      d[op*OP_WIDTH +: OP_WIDTH] = 16'(s*4096 + k*16 + op);
    return d;
  endfunction

  task automatic add_beat(input int s, input int k, input int cnt, input bit last);
    beat_t b;
    b.flush_only = 1'b0; b.last = last; b.cnt = COUNT_W'(cnt); b.data = mkdata(s, k);
    srcq[s].push_back(b);
  endtask

  task automatic add_flush_only(input int s);
    beat_t b;
    b.flush_only = 1'b1; b.last = 1'b0; b.cnt = '0; b.data = '0;
    srcq[s].push_back(b);
  endtask

  task automatic exp_beat(input int s, input int k, input int cnt, input int gap);
    exp_t e;
    e.is_flush = 1'b0; e.grant = NUM_SRC'(1) << s; e.cnt = COUNT_W'(cnt);
    e.data = mkdata(s, k); e.err = exp_err; e.gap = gap;
    expq.push_back(e);
    if (cnt == 0 || cnt > IN_COUNT) exp_err = 1'b1;
  endtask

  task automatic exp_flush(input int s, input int gap);
    exp_t e;
    e.is_flush = 1'b1; e.grant = NUM_SRC'(1) << s; e.cnt = '0;
    e.data = '0; e.err = exp_err; e.gap = gap;
    expq.push_back(e);
  endtask

  // Legal 'n'-beat burst from source s, last beat carries the flush marker.
  task automatic burst(input int s, input int n, input int first_gap);
    for (int k = 0; k < n; k++) begin
      add_beat(s, k, IN_COUNT, k == n - 1);
      exp_beat(s, k, IN_COUNT, (k == 0) ? first_gap : 1);
    end
    exp_flush(s, 1);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (srcq[i].size() > 0) begin
        src_req[i]   = !srcq[i][0].flush_only;
        src_flush[i] = srcq[i][0].flush_only | srcq[i][0].last;
        src_count[i*COUNT_W +: COUNT_W]  = srcq[i][0].cnt;
        src_data[i*IN_WIDTH +: IN_WIDTH] = srcq[i][0].data;
      end else begin
        src_req[i]   = 1'b0;
        src_flush[i] = 1'b0;
        src_count[i*COUNT_W +: COUNT_W]  = '0;
        src_data[i*IN_WIDTH +: IN_WIDTH] = '0;
      end
    end
  endtask

  task automatic step();
    logic [NUM_SRC-1:0] take;
    beat_t dummy;
    @(negedge clk);
    for (int i = 0; i < NUM_SRC; i++)
      take[i] = (src_req[i] & mon_ready[i]) |
                ((srcq[i].size() > 0) && srcq[i][0].flush_only && mon_grant[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++)
      if (take[i]) dummy = srcq[i].pop_front();
    drive();
  endtask

  function automatic bit pending();
    if (expq.size() != 0) return 1'b1;
    for (int i = 0; i < NUM_SRC; i++)
      if (srcq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input string name, input int maxc);
    int n;
    n = 0;
    while (pending() && n < maxc) begin
      step();
      n++;
    end
    n_total++;
    if (pending())
      $display("FAIL %s: timeout with %0d expected events left after %0d cycles",
               name, expq.size(), maxc);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
    drive();
    step();
    reset = 1'b1;
    exp_err = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_req || mon_flush) begin
      chk("req_flush_exclusive", mon_req & mon_flush, 1'b0);
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: req=%0b flush=%0b grant=%b, required no event",
                 mon_req, mon_flush, mon_grant);
      end else begin
        e = expq.pop_front();
        chk("event_kind_is_flush", mon_flush, e.is_flush);
        chk("event_grant", mon_grant, e.grant);
        if (e.is_flush) begin
          chk("flush_data_zero", mon_data, '0);
          chk("flush_count_zero", mon_count, '0);
        end else begin
          chk("beat_data", mon_data, e.data);
          chk("beat_count", mon_count, e.cnt);
          chk("beat_err_count", mon_err, e.err);
        end
        if (e.gap > 0) chk("event_gap", cyc - last_ev, e.gap);
      end
      last_ev = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    s_write_ready = 1'b1;
    use4 = 1'b0;
    exp_err = 1'b0;
    drive();
    step();
    step();
    #1;
    chk("rst_grant", a_grant, '0);
    chk("rst_grant_mb4", b_grant, '0);
    chk("rst_ready", a_ready, '0);
    chk("rst_req", a_req, 1'b0);
    chk("rst_flush", a_flush, 1'b0);
    chk("rst_count", a_count, '0);
    chk("rst_data", a_data, '0);
    chk("rst_err", a_err, 1'b0);
    reset = 1'b1;

    // Single source: 5 beats from src 1, then a bare flush marker.
    for (int k = 0; k < 5; k++) begin
      add_beat(1, k, 10, 1'b0);
      exp_beat(1, k, 10, (k == 0) ? 0 : 1);
    end
    add_flush_only(1);
    exp_flush(1, 2);
    wait_done("t1_single", 40);
    s_write_ready = 1'b0;       // hold the serdes busy in DRAIN
    #1;
    chk("t1_grant_in_drain", a_grant, 4'b0010);
    step();
    step();
    #1;
    chk("t1_grant_held", a_grant, 4'b0010);
    chk("t1_no_req_drain", a_req, 1'b0);
    s_write_ready = 1'b1;
    step();
    #1;
    chk("t1_grant_cleared", a_grant, '0);
    repeat (2) step();

    // All four sources at once, 2-beat bursts: grants 0,1,2,3, 3-cycle gaps.
    do_reset();
    burst(0, 2, 0);
    burst(1, 2, 3);
    burst(2, 2, 3);
    burst(3, 2, 3);
    wait_done("t2_round_robin", 80);
    repeat (3) step();

    // Backpressure: serdes stalls 4 cycles after 2 beats of src 2.
    for (int k = 0; k < 6; k++) begin
      add_beat(2, k, 10, k == 5);
      exp_beat(2, k, 10, (k == 0) ? 0 : (k == 2) ? 5 : 1);
    end
    exp_flush(2, 1);
    n = 0;
    while (srcq[2].size() > 4 && n < 20) begin
      step();
      n++;
    end
    chk("t3_two_beats_taken", srcq[2].size(), 4);
    s_write_ready = 1'b0;
    repeat (4) begin
      #1;
      chk("t3_src_ready_low", a_ready, '0);
      chk("t3_req_low", a_req, 1'b0);
      step();
    end
    s_write_ready = 1'b1;
    wait_done("t3_backpressure", 40);
    repeat (3) step();

    // Illegal counts: 0 and 11 are forwarded and make err_count sticky.
    chk("t5_err_before", a_err, 1'b0);
    add_beat(0, 0, 10, 1'b0); exp_beat(0, 0, 10, 0);
    add_beat(0, 1, 0,  1'b0); exp_beat(0, 1, 0,  1);
    add_beat(0, 2, 10, 1'b0); exp_beat(0, 2, 10, 1);
    add_beat(0, 3, 11, 1'b0); exp_beat(0, 3, 11, 1);
    add_beat(0, 4, 7,  1'b1); exp_beat(0, 4, 7,  1);
    exp_flush(0, 1);
    wait_done("t5_illegal_counts", 40);
    repeat (3) step();
    #1;
    chk("t5_err_sticky", a_err, 1'b1);
    do_reset();
    #1;
    chk("t5_err_cleared_by_reset", a_err, 1'b0);

    // Forced flush with MAX_BURST=4.
    use4 = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      add_beat(2, k, 10, k == 7);
      exp_beat(2, k, 10, (k == 0) ? 0 : (k == 4) ? 3 : 1);
      if (k == 3) exp_flush(2, 1);
    end
    exp_flush(2, 1);
    wait_done("t4_regrant_same", 60);
    repeat (3) step();
    for (int k = 0; k < 6; k++) add_beat(2, k, 10, k == 5);
    for (int k = 0; k < 4; k++) exp_beat(2, k, 10, (k == 0) ? 0 : 1);
    exp_flush(2, 1);
    exp_beat(3, 0, 10, 3);
    exp_flush(3, 1);
    exp_beat(2, 4, 10, 3);
    exp_beat(2, 5, 10, 1);
    exp_flush(2, 1);
    step();
    step();
    add_beat(3, 0, 10, 1'b1);
    wait_done("t4_forced_flush_rotate", 60);
    repeat (3) step();
    use4 = 1'b0;
    do_reset();

    // Reset mid-burst: src 0 completes a burst, src 1 is cut after 3 beats.
    burst(0, 2, 0);
    wait_done("t6_prelude", 30);
    repeat (3) step();
    for (int k = 0; k < 6; k++) add_beat(1, k, 10, 1'b0);
    for (int k = 0; k < 3; k++) exp_beat(1, k, 10, (k == 0) ? 0 : 1);
    n = 0;
    while (srcq[1].size() > 3 && n < 20) begin
      step();
      n++;
    end
    chk("t6_three_beats_taken", srcq[1].size(), 3);
    do_reset();
    #1;
    chk("t6_rst_grant", a_grant, '0);
    chk("t6_rst_req", a_req, 1'b0);
    chk("t6_rst_flush", a_flush, 1'b0);
    chk("t6_rst_ready", a_ready, '0);
    chk("t6_rst_data", a_data, '0);
    chk("t6_no_pending_events", expq.size(), 0);
    repeat (3) step();
    add_beat(2, 0, 10, 1'b1);
    add_beat(0, 0, 10, 1'b1);
    exp_beat(0, 0, 10, 0);
    exp_flush(0, 1);
    exp_beat(2, 0, 10, 3);
    exp_flush(2, 1);
    wait_done("t6_src0_first", 40);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
